gray_code: RTL and testbench
============================

Name:
gray_code

Overview:
- Registered 4-bit Gray-code unit.
- Supports three operations on a 4-bit word presented as single-bit inputs A (MSB) through D (LSB):
  - binary-to-Gray conversion (primary use)
  - Gray-to-binary conversion
  - Gray-code increment (next code in Gray sequence)
- Sits in datapaths needing single-bit-change encodings (counters, encoders, clock-domain pointer exchange).
- Result appears one clock after a valid input.

Parameters:
None. Width is fixed at 4 bits.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
A  input  1  input word bit 3 (MSB)
B  input  1  input word bit 2
C  input  1  input word bit 1
D  input  1  input word bit 0 (LSB)
mode  input  2  00 = binary->Gray, 01 = Gray->binary, 10 = Gray increment, 11 = pass-through
in_valid  input  1  input word and mode are valid this cycle
F  output  4  registered result, F[3] MSB
out_valid  output  1  F holds a new result this cycle
parity  output  1  registered XOR of the 4 bits of F

Behaviour:
- Clock and reset
  - Only clk is a clock; all state updates on rising edge.
  - reset sampled at rising edge; it has priority over everything else.
- Reset values: F = 4'b0000, out_valid = 0, parity = 0.
- Input word: X = {A,B,C,D}, with X[3] = A.
- Mode 00, binary->Gray:
  - G[3] = X[3]
  - G[i] = X[i+1] ^ X[i] for i = 2..0
- Mode 01, Gray->binary:
  - Bn[3] = X[3]
  - Bn[i] = Bn[i+1] ^ X[i] for i = 2..0
- Mode 10, Gray increment:
  - Convert X (as Gray) to binary.
  - Add 1 modulo 16; 15 wraps to 0.
  - Convert back to Gray; result is the next code in the reflected Gray sequence.
  - Gray 1000 -> 0000 (wrap).
- Mode 11: F <= X unchanged.
- Latency and handshake:
  - Cycle N with in_valid=1 and reset=0: at edge N, F <= result, parity <= ^result, out_valid <= 1.
  - Cycle with in_valid=0 and reset=0: F and parity hold their previous value; out_valid <= 0.
  - out_valid is a one-cycle pulse per accepted input.
  - Back-to-back valid inputs give back-to-back results, throughput 1 per cycle.
  - No backpressure.
- Reset mid-operation: reset=1 with in_valid=1 in the same cycle discards the input. Next cycle F=0, out_valid=0.
- Mode is sampled only with in_valid. Changing mode while in_valid=0 has no effect.
- Datapath is purely combinational before the single output register. No other internal state.

Test Plan:
- Reset: assert reset 2 cycles with in_valid=1, X=1111 -> F=0000, out_valid=0, parity=0. Deassert, in_valid=0 -> F stays 0000.
- Binary->Gray:
  - mode=00, {A,B,C,D}=0110, in_valid=1 -> next cycle F=0101 (F[3]=0, F[2]=1, F[1]=0, F[0]=1), out_valid=1, parity=0.
  - Sweep all 16 inputs, e.g. 1111 -> 1000, 0111 -> 0100, 1000 -> 1100.
- Gray->binary: mode=01, X=0101 -> F=0110. Round-trip all 16 values through mode 00 then mode 01 -> original value each time.
- Gray increment:
  - mode=10, X=0101 -> F=0100.
  - X=0000 -> F=0001.
  - Wrap: X=1000 -> F=0000.
  - Chain 16 increments from 0000 -> returns to 0000; each step differs by exactly one bit.
- Handshake and hold:
  - Valid input 0110 (mode 00), then 3 cycles in_valid=0 with X changing -> F holds 0101; out_valid high only the first cycle.
  - Back-to-back valid 0001 then 0010 (mode 00) -> F=0001 then F=0011 on consecutive cycles, out_valid high both.
- Mid-operation reset: in_valid=1, X=0110, reset=1 same cycle -> F=0000, out_valid=0. Mode 11 with X=1010 afterwards -> F=1010, parity=0.

Source files
------------

// File: rtl/gray_code.sv
// Registered 4-bit Gray-code unit: binary->Gray, Gray->binary, Gray increment, pass-through.
// One output register stage; result, parity and valid pulse appear one clock after an accepted input.
module gray_code (
    input  logic       clk,
    input  logic       reset,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       D,
    input  logic [1:0] mode,
    input  logic       in_valid,
    output logic [3:0] F,
    output logic       out_valid,
    output logic       parity
);

    typedef enum logic [1:0] {
        MODE_B2G  = 2'b00,
        MODE_G2B  = 2'b01,
        MODE_INC  = 2'b10,
        MODE_PASS = 2'b11
    } mode_t;

    function automatic logic [3:0] bin2gray(input logic [3:0] b);
        return b ^ {1'b0, b[3:1]};
    endfunction

    function automatic logic [3:0] gray2bin(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        b[2] = b[3] ^ g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    logic [3:0] w_x;
    logic [3:0] w_result;
    logic [3:0] r_f;
    logic       r_valid;
    logic       r_parity;

    assign w_x = {A, B, C, D};

    always_comb begin
        w_result = w_x;
        unique case (mode_t'(mode))
            MODE_B2G:  w_result = bin2gray(w_x);
            MODE_G2B:  w_result = gray2bin(w_x);
            // 4-bit add wraps 15 -> 0, giving Gray 1000 -> 0000
            MODE_INC:  w_result = bin2gray(gray2bin(w_x) + 4'd1);
            MODE_PASS: w_result = w_x;
            default:   w_result = w_x;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_f      <= '0;
            r_valid  <= 1'b0;
            r_parity <= 1'b0;
        end else if (in_valid) begin
            r_f      <= w_result;
            r_valid  <= 1'b1;
            r_parity <= ^w_result;
        end else begin
            r_valid  <= 1'b0;
        end
    end

    assign F         = r_f;
    assign out_valid = r_valid;
    assign parity    = r_parity;

endmodule

// File: tb/tb_gray_code.sv
// Scoreboard bench for gray_code: stimulus pushes hand-computed results into a queue,
// a negedge monitor pops on out_valid and otherwise checks that F/parity hold.
module tb_gray_code;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       A = 1'b0, B = 1'b0, C = 1'b0, D = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       in_valid = 1'b0;
    logic [3:0] F;
    logic       out_valid;
    logic       parity;

    always #5 clk = ~clk;

    gray_code dut (
        .clk       (clk),
        .reset     (reset),
        .A         (A),
        .B         (B),
        .C         (C),
        .D         (D),
        .mode      (mode),
        .in_valid  (in_valid),
        .F         (F),
        .out_valid (out_valid),
        .parity    (parity)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [3:0]  exp_q[$];
    logic [3:0]  hold_exp = '0;
    logic        rst_q    = 1'b0;
    logic        mon_en   = 1'b0;

    // Reflected Gray code of index i
    logic [3:0] gtab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                              4'b0110, 4'b0111, 4'b0101, 4'b0100,
                              4'b1100, 4'b1101, 4'b1111, 4'b1110,
                              4'b1010, 4'b1011, 4'b1001, 4'b1000};

    always @(posedge clk) rst_q <= reset;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_q) begin
                check("reset_F", F, 4'b0000);
                check("reset_out_valid", {3'b000, out_valid}, 4'b0000);
                check("reset_parity", {3'b000, parity}, 4'b0000);
                hold_exp = '0;
                exp_q.delete();
            end else if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out_valid: got F=%b with no pending input, expected none", F);
                end else begin
                    logic [3:0] e;
                    e = exp_q.pop_front();
                    check("result_F", F, e);
                    check("result_parity", {3'b000, parity}, {3'b000, ^e});
                    hold_exp = e;
                end
            end else begin
                check("idle_out_valid", {3'b000, out_valid}, 4'b0000);
                check("hold_F", F, hold_exp);
                check("hold_parity", {3'b000, parity}, {3'b000, ^hold_exp});
            end
        end
    end

    task automatic send(input logic [1:0] m, input logic [3:0] x, input logic [3:0] e);
        {A, B, C, D} = x;
        mode         = m;
        in_valid     = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        in_valid = 1'b0;
        for (int unsigned k = 0; k < n; k++) begin
            {A, B, C, D} = 4'($urandom);
            mode         = 2'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset held two cycles with a valid all-ones word that must be discarded
        reset = 1'b1; in_valid = 1'b1; {A, B, C, D} = 4'b1111; mode = 2'b00;
        @(posedge clk); #1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        idle(2);

        // Directed vectors
        send(2'b00, 4'b0110, 4'b0101);
        idle(3);
        send(2'b00, 4'b1111, 4'b1000);
        send(2'b00, 4'b0111, 4'b0100);
        send(2'b00, 4'b1000, 4'b1100);
        send(2'b01, 4'b0101, 4'b0110);
        send(2'b10, 4'b0101, 4'b0100);
        send(2'b10, 4'b0000, 4'b0001);
        send(2'b10, 4'b1000, 4'b0000);
        idle(1);

        // Binary->Gray sweep and Gray->binary round trip
        for (int i = 0; i < 16; i++) begin
            send(2'b00, 4'(i), gtab[i]);
            send(2'b01, gtab[i], 4'(i));
        end
        idle(1);

        // Increment chain around the full Gray cycle, back to 0000
        for (int i = 0; i < 16; i++)
            send(2'b10, gtab[i], gtab[(i + 1) % 16]);
        idle(2);

        // Back-to-back valid inputs
        send(2'b00, 4'b0001, 4'b0001);
        send(2'b00, 4'b0010, 4'b0011);
        idle(2);

        // Reset in the same cycle as a valid input discards it
        {A, B, C, D} = 4'b0110; mode = 2'b00; in_valid = 1'b1; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        idle(1);
        send(2'b11, 4'b1010, 4'b1010);
        idle(2);
        send(2'b11, 4'b1011, 4'b1011);
        idle(2);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_results: got %0d results never presented, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
